// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: round-robin burst arbiter that drains head words from
// NUM_PORTS source FIFOs onto one valid/ready output stream.
// Each grant carries up to BURST_LEN beats. The scan for the next port starts
// one past the last granted port, so ports take turns.
// Optional build macro: FIFO_ARB_STATS_EN adds per-port accepted-beat counters,
// read through stat_sel/stat_count.
module fifo_read_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int LOG_NUM_PORTS = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int BURST_LEN     = 4,
  parameter int LOG_BURST_LEN = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [NUM_PORTS-1:0]             port_mask,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  fifo_data,
  input  logic [NUM_PORTS-1:0]             fifo_empty,
  output logic [NUM_PORTS-1:0]             fifo_next_read,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LOG_NUM_PORTS-1:0]         grant_port,
`ifdef FIFO_ARB_STATS_EN
  input  logic [LOG_NUM_PORTS-1:0]         stat_sel,
  output logic [31:0]                      stat_count,
`endif
  output logic                             busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [LOG_BURST_LEN-1:0] LAST_BEAT = LOG_BURST_LEN'(BURST_LEN - 1);
  localparam logic [LOG_NUM_PORTS-1:0] LAST_PORT = LOG_NUM_PORTS'(NUM_PORTS - 1);

  state_t                     state, state_nxt;
  logic [LOG_NUM_PORTS-1:0]   grant_port_nxt;
  logic [LOG_NUM_PORTS-1:0]   last_grant, last_grant_nxt;
  logic [LOG_BURST_LEN-1:0]   burst_cnt, burst_cnt_nxt;
  logic [DATA_WIDTH-1:0]      words [NUM_PORTS];
  logic                       accept;
  logic                       pick_found;
  logic [LOG_NUM_PORTS-1:0]   pick_port_idx;

  // Round-robin pick: the first eligible port at offset 1..NUM_PORTS after
  // 'last'. The loop runs from the far offset down, so the nearest one is the
  // last assignment and wins. Returns {found, index}.
  function automatic logic [LOG_NUM_PORTS:0] pick_port(
    input logic [NUM_PORTS-1:0]     elig,
    input logic [LOG_NUM_PORTS-1:0] last
  );
    logic [LOG_NUM_PORTS:0] r;
    int                     idx;
    r = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_PORTS;
      if (elig[idx]) r = {1'b1, LOG_NUM_PORTS'(idx)};
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign words[gi] = fifo_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Output side: offer the granted head word. Outputs are forced quiet while
  // reset is held, so a burst cut by reset never pops.
  always_comb begin
    busy      = (state == GRANT) & rst;
    out_valid = busy & enable & ~fifo_empty[grant_port];
    out_data  = words[grant_port];
    accept    = out_valid & out_ready;
  end

  // Pop strobe: only the granted port, and only on an accepted beat.
  always_comb begin
    fifo_next_read             = '0;
    fifo_next_read[grant_port] = accept;
  end

  // Next-state logic: arbitration in IDLE, beat counting and grant end in GRANT.
  always_comb begin
    state_nxt      = state;
    grant_port_nxt = grant_port;
    burst_cnt_nxt  = burst_cnt;
    last_grant_nxt = last_grant;
    {pick_found, pick_port_idx} = pick_port(port_mask & ~fifo_empty, last_grant);
    case (state)
      IDLE: begin
        if (enable && pick_found) begin
          state_nxt      = GRANT;
          grant_port_nxt = pick_port_idx;
          burst_cnt_nxt  = '0;
        end
      end
      GRANT: begin
        if (!out_valid) begin
          // The source ran dry or arbitration is disabled: give up the grant.
          state_nxt      = IDLE;
          last_grant_nxt = grant_port;
        end else if (accept) begin
          burst_cnt_nxt = burst_cnt + LOG_BURST_LEN'(1);
          if (burst_cnt == LAST_BEAT) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant_port;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register. Reset leaves last_grant on the top port, so the first
  // scan begins at port 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant_port <= '0;
      burst_cnt  <= '0;
      last_grant <= LAST_PORT;
    end else begin
      state      <= state_nxt;
      grant_port <= grant_port_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] stat_cnt [NUM_PORTS];

  // Per-port accepted-beat counters. They wrap modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++) stat_cnt[i] <= '0;
    end else if (accept) begin
      stat_cnt[grant_port] <= stat_cnt[grant_port] + 32'd1;
    end
  end

  assign stat_count = stat_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter. It holds a queue per source FIFO and a
// grant-level reference model. It runs directed scenarios with hand-computed
// expectations, then a randomized run checked against the model every cycle.
module tb_fifo_read_arbiter;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [NP-1:0]   port_mask;
  logic [NP*DW-1:0] fifo_data;
  logic [NP-1:0]   fifo_empty;
  logic [NP-1:0]   fifo_next_read;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      grant_port;
  logic            busy;
  logic [1:0]      stat_sel;
  logic [31:0]     stat_count;

  fifo_read_arbiter #(
    .NUM_PORTS(NP), .LOG_NUM_PORTS(2), .DATA_WIDTH(DW), .BURST_LEN(BL), .LOG_BURST_LEN(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .port_mask(port_mask),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_next_read(fifo_next_read),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant_port(grant_port),
`ifdef FIFO_ARB_STATS_EN
    .stat_sel(stat_sel), .stat_count(stat_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Source FIFO contents, head at index 0.
  logic [DW-1:0] q [NP][$];
  bit            auto_fill = 0;

  // Reference model: is a grant active, on which port, beats so far,
  // the last port that held a grant, and accepted beats per port.
  bit          m_busy;
  int          m_port;
  int          m_beats;
  int          m_last;
  int unsigned m_stat [NP];

  // What happened in the most recent step.
  bit            cur_acc;
  logic [DW-1:0] cur_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle. Drive the FIFO heads at the falling edge and compare the
  // DUT against the model. After the rising edge, advance the model and the
  // queues, using the inputs that were stable across that edge.
  task automatic step();
    bit   exp_valid;
    bit   acc;
    bit   found;
    int   p;
    logic [NP-1:0] exp_pop;
    @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      fifo_empty[i]        = (q[i].size() == 0);
      fifo_data[i*DW +: DW] = (q[i].size() == 0) ? '0 : q[i][0];
    end
    stat_sel = 2'($urandom_range(0, NP - 1));
    #1;
    exp_valid = rst && m_busy && enable && (q[m_port].size() != 0);
    acc       = exp_valid && out_ready;
    exp_pop   = acc ? NP'(1 << m_port) : '0;
    chk("out_valid", out_valid, exp_valid);
    chk("busy", busy, rst && m_busy);
    chk("fifo_next_read", fifo_next_read, exp_pop);
    chk("grant_port", grant_port, m_port);
    if (exp_valid) chk("out_data", out_data, q[m_port][0]);
`ifdef FIFO_ARB_STATS_EN
    chk("stat_count", stat_count, m_stat[stat_sel]);
`endif
    cur_acc  = acc;
    cur_data = out_data;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_busy = 0; m_port = 0; m_beats = 0; m_last = NP - 1;
      for (int i = 0; i < NP; i++) m_stat[i] = 0;
    end else if (!m_busy) begin
      found = 0;
      if (enable) begin
        for (int k = 1; k <= NP; k++) begin
          p = (m_last + k) % NP;
          if (!found && port_mask[p] && q[p].size() != 0) begin
            found = 1; m_busy = 1; m_port = p; m_beats = 0;
          end
        end
      end
    end else begin
      if (acc) begin
        void'(q[m_port].pop_front());
        m_beats++;
        m_stat[m_port]++;
      end
      if (!exp_valid || (acc && m_beats == BL)) begin
        m_busy = 0;
        m_last = m_port;
      end
    end
    if (auto_fill) begin
      for (int i = 0; i < NP; i++)
        if ($urandom_range(0, 3) == 0 && q[i].size() < 6) q[i].push_back(DW'($urandom));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    chk("reset_grant_port", grant_port, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    rst = 1'b1;
  endtask

  initial begin
    int beats;
    int si;
    logic [7:0] exp_d;
    rst = 1'b0; enable = 1'b1; port_mask = '1; out_ready = 1'b1;
    fifo_data = '0; fifo_empty = '1; stat_sel = '0;
    m_busy = 0; m_port = 0; m_beats = 0; m_last = NP - 1;
    for (int i = 0; i < NP; i++) m_stat[i] = 0;

    // Round robin over four loaded ports: 4-beat bursts, one idle cycle between bursts.
    do_reset();
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < 8; i++) q[p].push_back(8'(p*16 + i));
    beats = 0;
    si = 0;
    while (beats < 32 && si < 60) begin
      step();
      if (cur_acc) begin
        exp_d = 8'(((beats/4)%4)*16 + (beats/16)*4 + beats%4);
        chk("rr_data", cur_data, exp_d);
        chk("rr_step", si, 1 + (beats/4)*5 + beats%4);
        beats++;
      end
      si++;
    end
    chk("rr_beats", beats, 32);
    enable = 1'b0;
    step();
`ifdef FIFO_ARB_STATS_EN
    for (int s = 0; s < NP; s++) begin
      stat_sel = 2'(s);
      #1;
      chk("stat_after_rr", stat_count, 8);
    end
`endif

    // Only port 2 holds data (2 words): the grant ends early, and the next scan starts at port 3.
    enable = 1'b1;
    do_reset();
    q[2].push_back(8'h55); q[2].push_back(8'h66);
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cur_acc) begin
        chk("p2_grant", grant_port, 2);
        beats++;
      end
    end
    chk("p2_beats", beats, 2);
    chk("p2_idle", busy, 0);
    for (int p = 0; p < NP; p++) q[p].push_back(8'h11);
    step();
    chk("p2_next_grant", grant_port, 3);
    for (int i = 0; i < 20; i++) step();

    // Stall on port 1: ready pattern 1,0,0,1. Only the first and last cycles pop, and the head is held.
    do_reset();
    for (int i = 0; i < NP; i++) q[i].delete();
    q[1].push_back(8'hA0); q[1].push_back(8'hA1); q[1].push_back(8'hA2); q[1].push_back(8'hA3);
    step();
    out_ready = 1'b1; step(); chk("stall_acc0", cur_acc, 1); chk("stall_d0", cur_data, 8'hA0);
    out_ready = 1'b0; step(); chk("stall_acc1", cur_acc, 0); chk("stall_d1", cur_data, 8'hA1);
    out_ready = 1'b0; step(); chk("stall_acc2", cur_acc, 0); chk("stall_d2", cur_data, 8'hA1);
    out_ready = 1'b1; step(); chk("stall_acc3", cur_acc, 1); chk("stall_d3", cur_data, 8'hA1);
    for (int i = 0; i < 6; i++) step();

    // Randomized traffic: reset pulses, enable drops, stalls and mask changes.
    auto_fill = 1;
    port_mask = 4'b1010;
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 63) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) port_mask = NP'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_read_arbiter.md
FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, shall set the number of source FIFOs arbitrated.
REQ-002 Parameter LOG_NUM_PORTS, default 2, shall set the width of the port index.
REQ-003 Parameter DATA_WIDTH, default 8, shall set the width of each FIFO data word.
REQ-004 Parameter BURST_LEN, default 4, shall set the maximum beats per grant (legal range 1..2^LOG_BURST_LEN).
REQ-005 Parameter LOG_BURST_LEN, default 2, shall set the burst counter width.
REQ-006 clk  input  1  clock; all state shall update on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 enable  input  1  arbitration enable; low blocks new grants and new beats.
REQ-009 port_mask  input  NUM_PORTS  bit i high makes port i eligible for a grant.
REQ-010 fifo_data  input  NUM_PORTS*DATA_WIDTH  head word of each FIFO; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 fifo_empty  input  NUM_PORTS  empty flag of each FIFO.
REQ-012 fifo_next_read  output  NUM_PORTS  one-cycle pop strobe to each FIFO.
REQ-013 out_data  output  DATA_WIDTH  selected head word.
REQ-014 out_valid  output  1  out_data is valid this cycle.
REQ-015 out_ready  input  1  consumer accepts the beat when out_valid and out_ready are both high.
REQ-016 grant_port  output  LOG_NUM_PORTS  index of the currently or last granted port.
REQ-017 busy  output  1  high while in state GRANT.

Function
REQ-018 The FSM shall have two states: IDLE and GRANT.
REQ-019 In IDLE with enable high, the block shall select the first port p with port_mask[p]=1 and fifo_empty[p]=0, scanning from (last_grant+1) mod NUM_PORTS upward with wrap-around; it shall load grant_port=p, clear burst_cnt and enter GRANT on the next edge.
REQ-020 In IDLE with no eligible port or enable low, the block shall remain in IDLE with out_valid=0 and all fifo_next_read=0.
REQ-021 In GRANT, out_valid shall equal enable & ~fifo_empty[grant_port], and out_data shall equal the grant_port slice of fifo_data, combinationally.
REQ-022 fifo_next_read[grant_port] shall equal out_valid & out_ready; every other fifo_next_read bit shall be 0 in every cycle.
REQ-023 Each accepted beat shall increment burst_cnt by one.
REQ-024 A beat accepted with burst_cnt==BURST_LEN-1 shall end the grant: next state IDLE, last_grant<=grant_port.
REQ-025 In GRANT, fifo_empty[grant_port]=1 or enable=0 shall end the grant on the next edge with last_grant<=grant_port, even if zero beats were transferred.
REQ-026 port_mask shall be sampled only in IDLE; mask changes during GRANT shall not affect the active grant.
REQ-027 Latency: an eligible port in IDLE at edge t shall give out_valid=1 in the cycle following edge t; exactly one IDLE cycle shall separate consecutive grants.
REQ-028 Stalls (out_ready=0) shall hold out_data and burst_cnt unchanged and issue no pop.

Reset
REQ-029 With rst low at a clock edge, state shall become IDLE, grant_port 0, burst_cnt 0, and last_grant NUM_PORTS-1, so the first scan starts at port 0.
REQ-030 During and immediately after reset, out_valid, busy and all fifo_next_read bits shall be 0; reset asserted mid-burst shall abort the burst without a pop in that cycle.

Configuration
REQ-031 Macro FIFO_ARB_STATS_EN, when defined, shall add input stat_sel (LOG_NUM_PORTS) and output stat_count (32), plus one 32-bit per-port accepted-beat counter, cleared by reset, wrapping at 2^32, and read combinationally through stat_sel.
REQ-032 Without FIFO_ARB_STATS_EN, the stat ports and counters shall not exist and all other behaviour shall be identical.

Verification
REQ-033 Reset then ports 0..3 each holding 8 words, mask 4'hF, out_ready=1 -> grants in order 0,1,2,3,0,... with 4 beats each and one idle cycle between bursts.
REQ-034 Only port 2 non-empty holding 2 words, BURST_LEN=4 -> 2 beats, then fifo_empty[2]=1 ends the grant, IDLE, last_grant=2.
REQ-035 Port 1 granted, out_ready toggled 1,0,0,1 -> pops only in cycles 1 and 4, out_data stable across the stall, burst_cnt=2.
REQ-036 mask=4'b1010 with all ports non-empty -> only ports 1 and 3 granted, alternating; clearing mask bit 3 mid-burst lets the burst on port 3 complete.
REQ-037 enable dropped in the 2nd beat of a burst -> out_valid=0 in the same cycle, IDLE on the next edge; reset asserted mid-burst -> IDLE, grant_port=0, no pops.
REQ-038 With FIFO_ARB_STATS_EN defined, after REQ-033 runs for 32 beats -> stat_count=8 for each stat_sel value 0..3.
